// File: rtl/av_io_pkg.sv
// Shared defaults and elaboration-time helpers for the board I/O sampling blocks.
package av_io_pkg;

    localparam int SAMPLE_PERIOD_DEFAULT = 65536;
    localparam int DEBOUNCE_N_DEFAULT    = 4;
    localparam int TS_W_DEFAULT          = 32;

    // Bits needed to hold values 0..value-1; never less than one so counters stay declarable.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input bit: 2-FF synchroniser, tick-gated debounce counter, level register and edge pulses.
module debounce_channel
    import av_io_pkg::*;
#(
    parameter int   DEBOUNCE_N  = DEBOUNCE_N_DEFAULT,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic ps_clko,
    input  logic ps_rstno,
    input  logic in_raw,
    input  logic tick,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int                CNT_W    = clog2(DEBOUNCE_N + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_q;
    logic             fall_q;

    // Stage p0/p1: metastability filter, then debounce evaluated on the sampled value.
    always_ff @(posedge ps_clko) begin
        if (!ps_rstno) begin
            sync_p0 <= RESET_LEVEL;
            sync_p1 <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_p0 <= in_raw;
            sync_p1 <= sync_p0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (tick) begin
                if (sync_p1 == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Enough consecutive disagreeing samples: commit the new level.
                    level_q <= sync_p1;
                    cnt_q   <= '0;
                    rise_q  <= sync_p1;
                    fall_q  <= ~sync_p1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/debounced_input_sampler.sv
// Multi-channel debounced input sampler with sticky, timestamped event latch for the PS GPIO.
module debounced_input_sampler
    import av_io_pkg::*;
#(
    parameter int   NUM_CH        = 8,
    parameter int   SAMPLE_PERIOD = SAMPLE_PERIOD_DEFAULT,
    parameter int   DEBOUNCE_N    = DEBOUNCE_N_DEFAULT,
    parameter int   TS_W          = TS_W_DEFAULT,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic              ps_clko,
    input  logic              ps_rstno,
    input  logic [NUM_CH-1:0] in_raw,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] evt_flags_o,
    output logic              evt_valid_o,
    output logic [TS_W-1:0]   evt_ts_o,
    input  logic              evt_ack_i,
    output logic [TS_W-1:0]   ts_o
);

    localparam int               TICK_W    = clog2(SAMPLE_PERIOD);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    logic [TS_W-1:0]   ts_q;
    logic [NUM_CH-1:0] edge_vec;
    logic              any_edge;
    logic [NUM_CH-1:0] flags_q;
    logic              evt_valid;
    logic [TS_W-1:0]   evt_ts_q;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge ps_clko) begin
        if (!ps_rstno) begin
            tick_cnt_q <= '0;
            ts_q       <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            ts_q       <= ts_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_N  (DEBOUNCE_N),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .ps_clko  (ps_clko),
            .ps_rstno (ps_rstno),
            .in_raw   (in_raw[i]),
            .tick     (tick),
            .level_o  (level_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i])
        );
    end

    assign edge_vec  = rise_o | fall_o;
    assign any_edge  = |edge_vec;
    assign evt_valid = |flags_q;

    // Stage p2: sticky event latch; an edge arriving with the ack starts a fresh event.
    always_ff @(posedge ps_clko) begin
        if (!ps_rstno) begin
            flags_q  <= '0;
            evt_ts_q <= '0;
        end else begin
            if (evt_ack_i && evt_valid) begin
                flags_q <= edge_vec;
            end else begin
                flags_q <= flags_q | edge_vec;
            end
            if (any_edge && (!evt_valid || evt_ack_i)) begin
                evt_ts_q <= ts_q;
            end
        end
    end

    assign evt_flags_o = flags_q;
    assign evt_valid_o = evt_valid;
    assign evt_ts_o    = evt_ts_q;
    assign ts_o        = ts_q;

endmodule

// File: tb/tb_debounced_input_sampler.sv
// Directed bench: NUM_CH=4, SAMPLE_PERIOD=4, DEBOUNCE_N=3, TS_W=8, RESET_LEVEL=0.
module tb_debounced_input_sampler;

    logic       ps_clko = 1'b0;
    logic       ps_rstno;
    logic [3:0] in_raw;
    logic [3:0] level_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic [3:0] evt_flags_o;
    logic       evt_valid_o;
    logic [7:0] evt_ts_o;
    logic       evt_ack_i;
    logic [7:0] ts_o;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [3:0] seen_rise;
    logic [3:0] seen_fall;

    debounced_input_sampler #(
        .NUM_CH        (4),
        .SAMPLE_PERIOD (4),
        .DEBOUNCE_N    (3),
        .TS_W          (8),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .ps_clko     (ps_clko),
        .ps_rstno    (ps_rstno),
        .in_raw      (in_raw),
        .level_o     (level_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .evt_flags_o (evt_flags_o),
        .evt_valid_o (evt_valid_o),
        .evt_ts_o    (evt_ts_o),
        .evt_ack_i   (evt_ack_i),
        .ts_o        (ts_o)
    );

    always #5 ps_clko = ~ps_clko;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ps_clko);
        #1;
        cyc++;
        seen_rise = seen_rise | rise_o;
        seen_fall = seen_fall | fall_o;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        ps_rstno  = 1'b0;
        in_raw    = 4'b0000;
        evt_ack_i = 1'b0;
        seen_rise = '0;
        seen_fall = '0;
        repeat (3) begin
            @(posedge ps_clko);
            #1;
        end
        check("rst_level", 32'(level_o), 32'h0);
        check("rst_rise", 32'(rise_o), 32'h0);
        check("rst_fall", 32'(fall_o), 32'h0);
        check("rst_flags", 32'(evt_flags_o), 32'h0);
        check("rst_valid", 32'(evt_valid_o), 32'h0);
        check("rst_evt_ts", 32'(evt_ts_o), 32'h0);
        check("rst_ts", 32'(ts_o), 32'h0);

        // Idle run with inputs low.
        ps_rstno = 1'b1;
        cyc = 0;
        run_to(50);
        check("idle_ts", 32'(ts_o), 32'd50);
        check("idle_level", 32'(level_o), 32'h0);
        check("idle_valid", 32'(evt_valid_o), 32'h0);
        check("idle_seen_rise", 32'(seen_rise), 32'h0);
        check("idle_seen_fall", 32'(seen_fall), 32'h0);

        // ch0 rises: synced at 52, samples at 56/60/64, flip after edge 64.
        in_raw[0] = 1'b1;
        seen_rise = '0;
        seen_fall = '0;
        run_to(63);
        check("ch0_pre_level", 32'(level_o), 32'h0);
        check("ch0_pre_rise", 32'(rise_o), 32'h0);
        run_to(64);
        check("ch0_level", 32'(level_o), 32'h1);
        check("ch0_rise", 32'(rise_o), 32'h1);
        check("ch0_ts", 32'(ts_o), 32'd64);
        run_to(65);
        check("ch0_rise_gone", 32'(rise_o), 32'h0);
        check("ch0_flags", 32'(evt_flags_o), 32'h1);
        check("ch0_valid", 32'(evt_valid_o), 32'h1);
        check("ch0_evt_ts", 32'(evt_ts_o), 32'd64);
        check("ch0_rise_once", 32'(seen_rise), 32'h1);

        // ch1 glitches high for two samples twice; counter must restart in between.
        seen_rise = '0;
        seen_fall = '0;
        in_raw[1] = 1'b1;
        run_to(71);
        in_raw[1] = 1'b0;
        run_to(77);
        in_raw[1] = 1'b1;
        run_to(83);
        in_raw[1] = 1'b0;
        run_to(90);
        check("glitch_level", 32'(level_o), 32'h1);
        check("glitch_flags", 32'(evt_flags_o), 32'h1);
        check("glitch_seen_rise", 32'(seen_rise), 32'h0);
        check("glitch_seen_fall", 32'(seen_fall), 32'h0);

        // Ack clears; second ack with nothing pending does nothing.
        evt_ack_i = 1'b1;
        run_to(91);
        evt_ack_i = 1'b0;
        check("ack_flags", 32'(evt_flags_o), 32'h0);
        check("ack_valid", 32'(evt_valid_o), 32'h0);
        run_to(92);
        evt_ack_i = 1'b1;
        run_to(93);
        evt_ack_i = 1'b0;
        check("ack2_flags", 32'(evt_flags_o), 32'h0);
        check("ack2_valid", 32'(evt_valid_o), 32'h0);
        check("ack2_level", 32'(level_o), 32'h1);

        // ch2 rises, then ch0 falls: second edge must not move evt_ts.
        in_raw[2] = 1'b1;
        run_to(104);
        check("ch2_rise", 32'(rise_o), 32'h4);
        check("ch2_level", 32'(level_o), 32'h5);
        run_to(105);
        check("ch2_flags", 32'(evt_flags_o), 32'h4);
        check("ch2_evt_ts", 32'(evt_ts_o), 32'd104);
        in_raw[0] = 1'b0;
        run_to(116);
        check("ch0_fall", 32'(fall_o), 32'h1);
        check("ch0_fall_level", 32'(level_o), 32'h4);
        run_to(117);
        check("two_flags", 32'(evt_flags_o), 32'h5);
        check("keep_evt_ts", 32'(evt_ts_o), 32'd104);
        evt_ack_i = 1'b1;
        run_to(118);
        evt_ack_i = 1'b0;
        check("ack3_flags", 32'(evt_flags_o), 32'h0);

        // ch0 pending, then ch2 fall lands in the ack cycle: new edge wins.
        in_raw[0] = 1'b1;
        run_to(132);
        check("ch0_rise2", 32'(rise_o), 32'h1);
        run_to(133);
        check("ch0_pend_flags", 32'(evt_flags_o), 32'h1);
        check("ch0_pend_ts", 32'(evt_ts_o), 32'd132);
        in_raw[2] = 1'b0;
        run_to(144);
        check("ch2_fall", 32'(fall_o), 32'h4);
        check("ch2_fall_level", 32'(level_o), 32'h1);
        evt_ack_i = 1'b1;
        run_to(145);
        evt_ack_i = 1'b0;
        check("ackedge_flags", 32'(evt_flags_o), 32'h4);
        check("ackedge_valid", 32'(evt_valid_o), 32'h1);
        check("ackedge_evt_ts", 32'(evt_ts_o), 32'd144);
        evt_ack_i = 1'b1;
        run_to(146);
        evt_ack_i = 1'b0;
        check("ack4_flags", 32'(evt_flags_o), 32'h0);

        // Timestamp wrap with a ch3 edge at cycle 260.
        run_to(248);
        in_raw[3] = 1'b1;
        run_to(255);
        check("ts_max", 32'(ts_o), 32'd255);
        run_to(256);
        check("ts_wrap", 32'(ts_o), 32'd0);
        run_to(260);
        check("ch3_rise", 32'(rise_o), 32'h8);
        check("ch3_ts", 32'(ts_o), 32'd4);
        run_to(261);
        check("ch3_evt_ts", 32'(evt_ts_o), 32'd4);
        check("ch3_flags", 32'(evt_flags_o), 32'h8);
        run_to(300);
        check("ts_300", 32'(ts_o), 32'd44);

        // ch1 debounce reaches cnt=2, then reset wipes the progress.
        in_raw[1] = 1'b1;
        run_to(309);
        check("pre_rst_level", 32'(level_o), 32'h9);
        ps_rstno = 1'b0;
        step();
        check("midrst_level", 32'(level_o), 32'h0);
        check("midrst_ts", 32'(ts_o), 32'h0);
        check("midrst_flags", 32'(evt_flags_o), 32'h0);
        check("midrst_valid", 32'(evt_valid_o), 32'h0);
        check("midrst_evt_ts", 32'(evt_ts_o), 32'h0);
        step();
        ps_rstno = 1'b1;
        cyc = 0;
        run_to(4);
        check("post_rst_lvl4", 32'(level_o), 32'h0);
        run_to(11);
        check("post_rst_lvl11", 32'(level_o), 32'h0);
        check("post_rst_ts11", 32'(ts_o), 32'd11);
        run_to(12);
        check("post_rst_lvl12", 32'(level_o), 32'hB);
        check("post_rst_rise12", 32'(rise_o), 32'hB);
        run_to(13);
        check("post_rst_flags", 32'(evt_flags_o), 32'hB);
        check("post_rst_evt_ts", 32'(evt_ts_o), 32'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
